// File: rtl/lsu_data_memory_if.sv
// lsu_data_memory_if: request/response bus between a core's load/store path and lsu_data_memory
interface lsu_data_memory_if #(parameter int ADDR_W = 10);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/lsu_data_memory.sv
// lsu_data_memory: byte/half/word data RAM with extension, misalignment errors and fixed-latency valid/ready access
module lsu_data_memory #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  lsu_data_memory_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAST = 4'(LATENCY - 1);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] mem [2**(ADDR_W-2)];
  logic [ADDR_W-3:0] idx;
  logic [1:0] off, size;
  logic acc, err;
  logic [3:0] be;
  logic [31:0] wd, word, ld, rdata;
  logic [7:0] b;
  logic [15:0] h;
  logic rerr;
  assign idx  = bus.req_addr[ADDR_W-1:2];
  assign off  = bus.req_addr[1:0];
  assign size = bus.req_size;
  assign acc  = bus.req_valid && state == IDLE;
  assign err  = size == 2'b11 || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
  assign be   = size == 2'b00 ? 4'b0001 << off : size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd   = size == 2'b00 ? {4{bus.req_wdata[7:0]}} : size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  assign word = mem[idx];
  assign b    = word[{off, 3'b000} +: 8];
  assign h    = off[1] ? word[31:16] : word[15:0];
  assign ld   = size == 2'b00 ? (bus.req_unsigned ? {24'b0, b} : {{24{b[7]}}, b}) :
                size == 2'b01 ? (bus.req_unsigned ? {16'b0, h} : {{16{h[15]}}, h}) : word;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (acc) begin
        state_nx = LATENCY > 1 ? WAIT : RESP;
        cnt_nx = 4'd1;
      end
      WAIT: begin
        state_nx = cnt == LAST ? RESP : WAIT;
        cnt_nx = cnt == LAST ? cnt : cnt + 4'd1;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      rerr <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (acc) begin
        rerr <= err;
        rdata <= (err || bus.req_we) ? 32'b0 : ld;
      end
    end
  end
  // Storage is deliberately left out of reset so contents survive a mid-operation reset
  always_ff @(posedge clk)
    if (acc && bus.req_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  assign bus.req_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = rerr;
endmodule

// File: tb/tb_lsu_data_memory.sv
// tb_lsu_data_memory: directed checks of lsu_data_memory at LATENCY=1 and LATENCY=4
module tb_lsu_data_memory;
  logic clk = 1'b0;
  logic r1_n = 1'b0;
  logic r4_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] dat [3];
  always #5 clk = ~clk;
  lsu_data_memory_if #(.ADDR_W(10)) i1 ();
  lsu_data_memory_if #(.ADDR_W(10)) i4 ();
  lsu_data_memory #(.ADDR_W(10), .LATENCY(1)) d1 (.clk(clk), .reset_n(r1_n), .bus(i1));
  lsu_data_memory #(.ADDR_W(10), .LATENCY(4)) d4 (.clk(clk), .reset_n(r4_n), .bus(i4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set1(input logic we, input logic [9:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd);
    i1.req_valid = 1'b1; i1.req_we = we; i1.req_addr = a; i1.req_size = sz; i1.req_unsigned = u; i1.req_wdata = wd;
  endtask

  task automatic set4(input logic we, input logic [9:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd);
    i4.req_valid = 1'b1; i4.req_we = we; i4.req_addr = a; i4.req_size = sz; i4.req_unsigned = u; i4.req_wdata = wd;
  endtask

  task automatic req1(input string tag, input logic we, input logic [9:0] a, input logic [1:0] sz, input logic u,
                      input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    set1(we, a, sz, u, wd);
    @(posedge clk); #1;
    i1.req_valid = 1'b0;
    chk({tag, ".valid"}, {31'b0, i1.rsp_valid}, 1);
    chk({tag, ".rdata"}, i1.rsp_rdata, ed);
    chk({tag, ".err"}, {31'b0, i1.rsp_err}, {31'b0, ee});
    @(posedge clk); #1;
    chk({tag, ".idle"}, {30'b0, i1.rsp_valid, i1.req_ready}, 32'd1);
  endtask

  task automatic req4(input string tag, input logic we, input logic [9:0] a, input logic [1:0] sz, input logic u,
                      input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    set4(we, a, sz, u, wd);
    @(posedge clk); #1;
    i4.req_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk({tag, ".wait"}, {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b010);
      @(posedge clk); #1;
    end
    chk({tag, ".resp"}, {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b110);
    chk({tag, ".rdata"}, i4.rsp_rdata, ed);
    chk({tag, ".err"}, {31'b0, i4.rsp_err}, {31'b0, ee});
    @(posedge clk); #1;
    chk({tag, ".idle"}, {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b001);
  endtask

  initial begin
    i1.req_valid = 0; i1.req_we = 0; i1.req_addr = '0; i1.req_size = 0; i1.req_unsigned = 0; i1.req_wdata = 0;
    i4.req_valid = 0; i4.req_we = 0; i4.req_addr = '0; i4.req_size = 0; i4.req_unsigned = 0; i4.req_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst1.ctl", {29'b0, i1.rsp_valid, i1.busy, i1.req_ready}, 32'b001);
    chk("rst1.rsp", {i1.rsp_rdata[31:1], i1.rsp_rdata[0] | i1.rsp_err}, 0);
    chk("rst4.ctl", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b001);
    r1_n = 1'b1; r4_n = 1'b1;
    @(posedge clk); #1;
    req1("sw010", 1, 10'h010, 2'b10, 0, 32'hDEADBEEF, 0, 0);
    req1("lw010", 0, 10'h010, 2'b10, 0, 0, 32'hDEADBEEF, 0);
    req1("sw020", 1, 10'h020, 2'b10, 0, 32'h0, 0, 0);
    req1("sb023", 1, 10'h023, 2'b00, 0, 32'h000000F0, 0, 0);
    req1("sh020", 1, 10'h020, 2'b01, 0, 32'h00008001, 0, 0);
    req1("lw020", 0, 10'h020, 2'b10, 0, 0, 32'hF0008001, 0);
    req1("lb023", 0, 10'h023, 2'b00, 0, 0, 32'hFFFFFFF0, 0);
    req1("lbu023", 0, 10'h023, 2'b00, 1, 0, 32'h000000F0, 0);
    req1("lb021", 0, 10'h021, 2'b00, 0, 0, 32'hFFFFFF80, 0);
    req1("lh020", 0, 10'h020, 2'b01, 0, 0, 32'hFFFF8001, 0);
    req1("lhu020", 0, 10'h020, 2'b01, 1, 0, 32'h00008001, 0);
    req1("lhu022", 0, 10'h022, 2'b01, 1, 0, 32'h0000F000, 0);
    req1("sw022", 1, 10'h022, 2'b10, 0, 32'h12345678, 0, 1);
    req1("sh021", 1, 10'h021, 2'b01, 0, 32'h0000BEEF, 0, 1);
    req1("sz11", 0, 10'h000, 2'b11, 0, 0, 0, 1);
    req1("lw020b", 0, 10'h020, 2'b10, 0, 0, 32'hF0008001, 0);
    req1("lw021", 0, 10'h021, 2'b10, 0, 0, 0, 1);
    req1("lw020c", 0, 10'h020, 2'b10, 0, 0, 32'hF0008001, 0);
    req4("sw050", 1, 10'h050, 2'b10, 0, 32'h13579BDF, 0, 0);
    // load at edge k with a store held on the bus while busy
    set4(0, 10'h050, 2'b10, 0, 0);
    @(posedge clk); #1;
    set4(1, 10'h054, 2'b10, 0, 32'h11112222);
    for (int j = 0; j < 4; j++) begin
      chk("hold.busy", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, j == 3 ? 32'b110 : 32'b010);
      if (j == 3) chk("hold.rdata", i4.rsp_rdata, 32'h13579BDF);
      @(posedge clk); #1;
    end
    chk("hold.idle", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b001);
    @(posedge clk); #1;
    i4.req_valid = 1'b0;
    chk("hold.acc", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b010);
    repeat (4) @(posedge clk);
    #1;
    req4("lw054", 0, 10'h054, 2'b10, 0, 0, 32'h11112222, 0);
    req4("lh056", 0, 10'h056, 2'b01, 0, 0, 32'h00001111, 0);
    // reset during WAIT drops the response but keeps the committed store
    set4(1, 10'h030, 2'b10, 0, 32'hA5A5A5A5);
    @(posedge clk); #1;
    i4.req_valid = 1'b0;
    chk("mid.busy", {31'b0, i4.busy}, 1);
    @(posedge clk); #1;
    r4_n = 1'b0;
    #1;
    chk("mid.rst", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b001);
    chk("mid.rsp", {i4.rsp_rdata[31:1], i4.rsp_rdata[0] | i4.rsp_err}, 0);
    @(posedge clk); #1;
    r4_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("mid.novalid", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b001);
      @(posedge clk); #1;
    end
    req4("lw030", 0, 10'h030, 2'b10, 0, 0, 32'hA5A5A5A5, 0);
    dat[0] = 32'h0BADF00D; dat[1] = 32'h600DCAFE; dat[2] = 32'h01234567;
    set4(1, 10'h040, 2'b10, 0, dat[0]);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (n == 5) i4.req_valid = 1'b0;
      else if (n[0]) set4(1, 10'h040, 2'b10, 0, dat[(n+1)/2]);
      else set4(0, 10'h040, 2'b10, 0, 0);
      for (int j = 0; j < 3; j++) begin
        chk("b2b.wait", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b010);
        @(posedge clk); #1;
      end
      chk("b2b.resp", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b110);
      chk("b2b.rdata", i4.rsp_rdata, n[0] ? dat[n/2] : 32'h0);
      @(posedge clk); #1;
      chk("b2b.ready", {29'b0, i4.rsp_valid, i4.busy, i4.req_ready}, 32'b001);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_data_memory.md
Name: lsu_data_memory

Overview:
- Parametrised successor to the single-port word data memory used with the single-cycle core.
- Adds byte, halfword and word accesses (RV32 SB/SH/SW and LB/LBU/LH/LHU/LW).
- Adds sign/zero extension on loads, misalignment detection, configurable access latency and a valid/ready request handshake.
- Sits between the core's load/store path and on-chip RAM, so later pipelined or multi-cycle cores can stall on memory.

Parameters:
ADDR_W, 10, byte-address width; storage depth = 2**(ADDR_W-2) 32-bit words
LATENCY, 1, cycles from request acceptance to response; legal range 1..8

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  qualifies rsp_valid: misaligned or illegal-size request
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync deassert use):
  - State = IDLE, latency counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, req_ready = 1.
  - Memory array is not cleared.
- FSM states:
  - IDLE: req_ready = 1. Request is accepted on the edge where req_valid & req_ready. Go to WAIT if LATENCY > 1, else RESP.
  - WAIT: counter counts 1 .. LATENCY-1. Go to RESP when counter = LATENCY-1.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- req_ready = (state == IDLE). Requests presented while not ready are ignored. Max throughput is one request per LATENCY+1 cycles.
- No response backpressure. The requester must capture rsp_* during the rsp_valid cycle.
- Error check at acceptance:
  - Error if size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 00.
  - On error: no memory write; response carries rsp_err = 1, rsp_rdata = 0, with normal latency.
- Stores commit to memory on the acceptance edge. Lane select uses addr[1:0]:
  - SB writes byte lane addr[1:0] only.
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Other lanes are unchanged.
  - Store response: rsp_rdata = 0, rsp_err = 0.
- Loads:
  - Word mem[addr[ADDR_W-1:2]] is captured at the acceptance edge.
  - The lane is extracted by addr[1:0] (half by addr[1]) and extended per req_unsigned. req_unsigned is ignored for words.
  - Extended value is held in the response register and driven during RESP.
- rsp_rdata and rsp_err hold their last value outside RESP; only rsp_valid qualifies them.
- Read-after-write: a load accepted after a store's RESP cycle returns the new data.
- Reset mid-operation (WAIT or RESP):
  - Pending response is dropped and rsp_valid goes 0 immediately.
  - A store already accepted stays committed.
- Address bits above the array depth do not exist (ADDR_W defines the whole space). No wrap logic is needed.

Test Plan:
- LATENCY=1: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_valid one cycle after each accept edge; load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Byte/half stores and extended loads (LATENCY=1):
  - After word 0x00000000 at 0x020, SB 0x023 data 0x000000F0 and SH 0x020 data 0x00008001.
  - LW 0x020 -> 0xF0008001.
  - LB 0x023 -> 0xFFFFFFF0; LBU 0x023 -> 0x000000F0.
  - LH 0x020 -> 0xFFFF8001; LHU 0x020 -> 0x00008001.
- Misalignment: SW 0x022 data 0x12345678, SH 0x021, size=11 at 0x000 -> each gives rsp_err = 1, rsp_rdata = 0; LW 0x020 afterwards still 0xF0008001.
- LATENCY=4: LW accepted at edge k -> busy high, req_ready low for edges k+1..k+4; rsp_valid high only in the cycle after edge k+3; a req_valid held during busy is not accepted until IDLE.
- Reset mid-op (LATENCY=4): SW 0x030 0xA5A5A5A5 accepted, reset_n pulsed low during WAIT -> outputs return to reset values asynchronously, no rsp_valid appears; a subsequent LW 0x030 returns 0xA5A5A5A5.
- Back-to-back: req_valid held high with alternating SW/LW to 0x040 -> accepts exactly every LATENCY+1 cycles; every load returns the data of the preceding store.
